// File: rtl/easyaxi_order_ll.sv
// Shared-pool linked-list order tracker for outstanding AXI transactions.
// Optional duplicate-slot checking is enabled by defining EASYAXI_ORDER_DUP_CHK_EN.
module easyaxi_order_ll #(
    parameter int unsigned OST_DEPTH  = 16,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MAX_ID_OST = 8,
    localparam int unsigned PTR_W     = $clog2(OST_DEPTH),
    localparam int unsigned CNT_W     = $clog2(MAX_ID_OST + 1),
    localparam int unsigned OST_W     = PTR_W + 1,
    localparam int unsigned ID_NUM    = 2 ** ID_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_ready,
    input  logic [ID_WIDTH-1:0]  req_id,
    input  logic [PTR_W-1:0]     req_ptr,
    output logic                 req_id_full,
    input  logic                 resp_valid,
    input  logic                 resp_ready,
    input  logic [ID_WIDTH-1:0]  resp_id,
    input  logic                 resp_last,
    output logic [PTR_W-1:0]     resp_ptr,
    output logic                 resp_hit,
    output logic [OST_DEPTH-1:0] resp_bits,
    output logic [OST_W-1:0]     ost_cnt,
    output logic                 err_underflow
`ifdef EASYAXI_ORDER_DUP_CHK_EN
    ,
    output logic                 err_dup_ptr
`endif
);

    logic [PTR_W-1:0] head_q [ID_NUM];
    logic [PTR_W-1:0] tail_q [ID_NUM];
    logic [CNT_W-1:0] cnt_q  [ID_NUM];
    logic [PTR_W-1:0] next_q [OST_DEPTH];

    logic req_hs;
    logic resp_hs;
    logic push;
    logic pop;
    logic same_id;
    logic push_cnt_zero;
    logic pop_cnt_one;

    assign req_id_full = (cnt_q[req_id] == CNT_W'(MAX_ID_OST));
    assign resp_hit    = (cnt_q[resp_id] != '0);
    assign resp_ptr    = resp_hit ? head_q[resp_id] : '0;

    assign req_hs        = req_valid & req_ready;
    assign resp_hs       = resp_valid & resp_ready & resp_last;
    assign pop           = resp_hs & resp_hit;
    assign same_id       = (req_id == resp_id);
    assign push_cnt_zero = (cnt_q[req_id] == '0);
    assign pop_cnt_one   = (cnt_q[resp_id] == CNT_W'(1));

`ifdef EASYAXI_ORDER_DUP_CHK_EN
    logic [OST_DEPTH-1:0] live_q;
    logic                 dup;

    // A slot being freed by this cycle's pop may be reused by this cycle's push
    assign dup  = live_q[req_ptr] & ~(pop & (head_q[resp_id] == req_ptr));
    assign push = req_hs & ~req_id_full & ~dup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= '0;
            err_dup_ptr <= 1'b0;
        end else begin
            if (pop) begin
                live_q[head_q[resp_id]] <= 1'b0;
            end
            if (push) begin
                live_q[req_ptr] <= 1'b1;
            end
            if (req_hs && dup) begin
                err_dup_ptr <= 1'b1;
            end
        end
    end
`else
    assign push = req_hs & ~req_id_full;
`endif

    // Per-ID head/tail/count; a later push write to head overrides the pop advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ID_NUM); i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                head_q[resp_id] <= next_q[head_q[resp_id]];
            end
            if (push) begin
                tail_q[req_id] <= req_ptr;
                if (push_cnt_zero || (pop && same_id && pop_cnt_one)) begin
                    head_q[req_id] <= req_ptr;
                end
            end
            if (push && !(pop && same_id)) begin
                cnt_q[req_id] <= cnt_q[req_id] + CNT_W'(1);
            end
            if (pop && !(push && same_id)) begin
                cnt_q[resp_id] <= cnt_q[resp_id] - CNT_W'(1);
            end
        end
    end

    // Link table is fully overwritten before use, so it carries no reset
    always_ff @(posedge clk) begin
        if (push && !push_cnt_zero) begin
            next_q[tail_q[req_id]] <= req_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ost_cnt       <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (push && !pop) begin
                ost_cnt <= ost_cnt + OST_W'(1);
            end else if (pop && !push) begin
                ost_cnt <= ost_cnt - OST_W'(1);
            end
            if (resp_hs && !resp_hit) begin
                err_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        resp_bits = '0;
        for (int i = 0; i < int'(ID_NUM); i++) begin
            if (cnt_q[i] != '0) begin
                resp_bits[head_q[i]] = 1'b1;
            end
        end
    end

endmodule

// File: doc/easyaxi_order_ll.md
Name: easyaxi_order_ll

Overview:
Shared-pool, linked-list order tracker for outstanding AXI transactions. It replaces per-ID FIFO storage with a single OST_DEPTH-entry next-pointer table and per-ID head/tail/count registers, so storage scales with OST_DEPTH rather than ID_NUM*OST_DEPTH. It sits between a master/slave outstanding-slot buffer and the response path. It reports, per response ID, the oldest slot pointer plus a bitmap of all per-ID oldest slots. It adds per-ID outstanding limiting and underflow error reporting.

Parameters:
OST_DEPTH, 16, total outstanding slots; power of two, ≥2; slot pointer width PTR_W = $clog2(OST_DEPTH).
ID_WIDTH, 4, AXI ID width; ID_NUM = 2**ID_WIDTH lists.
MAX_ID_OST, 8, per-ID outstanding limit; 1 ≤ MAX_ID_OST ≤ OST_DEPTH; count width CNT_W = $clog2(MAX_ID_OST+1).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request channel valid
req_ready  in  1  request channel ready; push when req_valid&req_ready
req_id  in  ID_WIDTH  request ID
req_ptr  in  PTR_W  slot index allocated by owner for this request
req_id_full  out  1  comb: count[req_id]==MAX_ID_OST; owner must gate req_ready with it
resp_valid  in  1  response valid
resp_ready  in  1  response ready
resp_id  in  ID_WIDTH  response ID
resp_last  in  1  last beat; pop when resp_valid&resp_ready&resp_last&resp_hit
resp_ptr  out  PTR_W  comb: head[resp_id]; 0 when list empty
resp_hit  out  1  comb: count[resp_id]!=0
resp_bits  out  OST_DEPTH  comb: OR over IDs of one-hot(head[i]) for non-empty lists
ost_cnt  out  PTR_W+1  registered total outstanding entries
err_underflow  out  1  sticky: response last handshake on empty ID

Behaviour:
- Reset (async, rst=1): all counts 0, heads/tails 0, ost_cnt 0, err_underflow 0. The next table is not reset. Outputs derived from state: resp_hit=0, resp_bits=0, resp_ptr=0, req_id_full=0.
- Push (req handshake, id=I, ptr=P):
  - count[I]==0: head[I]<=P, tail[I]<=P.
  - Otherwise: next[tail[I]]<=P, tail[I]<=P.
  - count[I]+1.
  - Visible on outputs the cycle after the handshake; no same-cycle bypass.
- Pop (resp last handshake, id=J, resp_hit=1): head[J]<=next[head[J]], count[J]-1. When count[J] was 1, head holds stale data and resp_hit=0 masks it.
- Non-last beats never pop. Order within an ID is strict FIFO; lists for different IDs are independent.
- Simultaneous push and pop:
  - Different IDs: both apply.
  - Same ID, count>1: head advances, tail appends, count unchanged.
  - Same ID, count==1: head<=P, tail<=P, count stays 1.
  - Same ID, count==0: only the push applies; the pop is an underflow.
- ost_cnt: +1 on push, −1 on valid pop, net 0 when both occur; never exceeds OST_DEPTH.
- Push when count[I]==MAX_ID_OST is a protocol violation. The block ignores it (no state change) and counts do not wrap.
- Underflow: resp_valid&resp_ready&resp_last&~resp_hit sets err_underflow=1, which stays set until rst. No state change.
- req_ptr uniqueness across live entries is the owner's responsibility; it is checked only when the optional feature is enabled.
- Reset mid-operation clears all lists immediately; in-flight handshakes in that cycle are lost.

Optional Feature:
Macro EASYAXI_ORDER_DUP_CHK_EN.
- Defined:
  - Adds a live-slot bitmap (OST_DEPTH bits, reset 0): set on push, cleared on pop of the old head.
  - Adds output err_dup_ptr (1 bit, sticky), set when a push presents a req_ptr whose bit is already set and not being freed in the same cycle.
  - The offending push is dropped.
- Not defined: no bitmap, no err_dup_ptr port, duplicate pushes corrupt lists silently.

Test Plan:
- Reset then idle → resp_hit=0, resp_bits=0, ost_cnt=0, err_underflow=0.
- Push ID3 ptrs 5,9,2 in consecutive cycles; then resp_id=3 last beats → resp_ptr 5,9,2 in order; resp_bits 0x0020, 0x0200, 0x0004, then 0; ost_cnt 3→0.
- Interleave: push ID1 ptr0, ID2 ptr1, ID1 ptr4 → resp_bits=0x0003. Pop ID1 → resp_bits=0x0012. Pop ID2 → resp_bits=0x0010.
- Same-cycle push ID7 ptr6 and pop ID7 while count[7]==1 (head ptr3) → next cycle resp_ptr(7)=6, count 1, ost_cnt unchanged.
- MAX_ID_OST=8: eight pushes on ID0 → req_id_full=1. A ninth forced push is ignored; ost_cnt stays 8.
- Pop last beat on empty ID5 → err_underflow=1, stays set through further traffic until rst pulse. With EASYAXI_ORDER_DUP_CHK_EN: push ptr4 twice on live slot → err_dup_ptr=1, second push dropped.
